// File: rtl/register_file_mp.sv
// Multi-port register file for the decode stage.
// Two write ports (port 1 wins on an address collision), NUM_READ combinational
// read ports with optional same-cycle write forwarding, an optional hard-wired
// zero register, and a per-register busy scoreboard for hazard detection.
module register_file_mp #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_READ   = 5,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                           Clock,
  input  logic                           ResetN,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] ReadAddr,
  output logic [NUM_READ*DATA_WIDTH-1:0] ReadData,
  output logic [NUM_READ-1:0]            ReadBusy,
  input  logic                           WriteEnable0,
  input  logic [ADDR_WIDTH-1:0]          WriteAddr0,
  input  logic [DATA_WIDTH-1:0]          WriteData0,
  input  logic                           WriteEnable1,
  input  logic [ADDR_WIDTH-1:0]          WriteAddr1,
  input  logic [DATA_WIDTH-1:0]          WriteData1,
  input  logic                           ReserveEnable,
  input  logic [ADDR_WIDTH-1:0]          ReserveAddr
);

  localparam int                    DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

  // True when the address is the hard-wired zero register.
  function automatic logic is_zero_reg(input logic [ADDR_WIDTH-1:0] addr);
    return (ZERO_REG != 0) && (addr == ADDR_ZERO);
  endfunction

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]      busy_q;
  logic [DEPTH-1:0]      busy_d;

  logic                  wr0_ok_s;
  logic                  wr1_ok_s;
  logic                  rsv_ok_s;
  logic [ADDR_WIDTH-1:0] rd_addr_s [NUM_READ];

  // Qualify write and reserve requests against the zero register.
  always_comb begin
    wr0_ok_s = WriteEnable0  && !is_zero_reg(WriteAddr0);
    wr1_ok_s = WriteEnable1  && !is_zero_reg(WriteAddr1);
    rsv_ok_s = ReserveEnable && !is_zero_reg(ReserveAddr);
  end

  // Next register and busy state: port 1 overrides port 0, reserve overrides the write clear.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = (wr1_ok_s && (WriteAddr1 == ADDR_WIDTH'(i))) ? WriteData1 :
                  (wr0_ok_s && (WriteAddr0 == ADDR_WIDTH'(i))) ? WriteData0 :
                  regs_q[i];
      busy_d[i] = (rsv_ok_s && (ReserveAddr == ADDR_WIDTH'(i))) ? 1'b1 :
                  ((wr0_ok_s && (WriteAddr0 == ADDR_WIDTH'(i))) ||
                   (wr1_ok_s && (WriteAddr1 == ADDR_WIDTH'(i)))) ? 1'b0 :
                  busy_q[i];
    end
  end

  // State registers; asynchronous reset clears contents and scoreboard together.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= DATA_ZERO;
      end
      busy_q <= {DEPTH{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q <= busy_d;
    end
  end

  // Unpack the per-port read addresses.
  always_comb begin
    for (int k = 0; k < NUM_READ; k++) begin
      rd_addr_s[k] = ReadAddr[k*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  // Combinational read ports with zero-register masking and write forwarding.
  always_comb begin
    ReadData = {(NUM_READ*DATA_WIDTH){1'b0}};
    ReadBusy = {NUM_READ{1'b0}};
    for (int k = 0; k < NUM_READ; k++) begin
      if (is_zero_reg(rd_addr_s[k])) begin
        ReadData[k*DATA_WIDTH +: DATA_WIDTH] = DATA_ZERO;
        ReadBusy[k]                          = 1'b0;
      end else if ((BYPASS != 0) && WriteEnable1 && (WriteAddr1 == rd_addr_s[k])) begin
        ReadData[k*DATA_WIDTH +: DATA_WIDTH] = WriteData1;
        ReadBusy[k]                          = 1'b0;
      end else if ((BYPASS != 0) && WriteEnable0 && (WriteAddr0 == rd_addr_s[k])) begin
        ReadData[k*DATA_WIDTH +: DATA_WIDTH] = WriteData0;
        ReadBusy[k]                          = 1'b0;
      end else begin
        ReadData[k*DATA_WIDTH +: DATA_WIDTH] = regs_q[rd_addr_s[k]];
        ReadBusy[k]                          = busy_q[rd_addr_s[k]];
      end
    end
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp with default parameters
// (16-bit data, 16 registers, 5 read ports, zero register and forwarding on).
module tb_register_file_mp;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int NR = 5;

  logic             clk;
  logic             rst_n;
  logic [NR*AW-1:0] read_addr;
  logic [NR*DW-1:0] read_data;
  logic [NR-1:0]    read_busy;
  logic             we0, we1, rsv;
  logic [AW-1:0]    wa0, wa1, rsa;
  logic [DW-1:0]    wd0, wd1;

  register_file_mp #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .Clock(clk), .ResetN(rst_n),
    .ReadAddr(read_addr), .ReadData(read_data), .ReadBusy(read_busy),
    .WriteEnable0(we0), .WriteAddr0(wa0), .WriteData0(wd0),
    .WriteEnable1(we1), .WriteAddr1(wa1), .WriteData1(wd1),
    .ReserveEnable(rsv), .ReserveAddr(rsa)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One table record: one cycle of stimulus plus the expected port-0 result.
  typedef struct packed {
    logic          we0;
    logic [AW-1:0] wa0;
    logic [DW-1:0] wd0;
    logic          we1;
    logic [AW-1:0] wa1;
    logic [DW-1:0] wd1;
    logic          rsv;
    logic [AW-1:0] rsa;
    logic          spread;   // 1: port k reads ra+k, 0: every port reads ra
    logic [AW-1:0] ra;
    logic [DW-1:0] exp_d;
    logic          exp_b;
  } vec_t;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          b;
  } exp_t;

  vec_t          tbl[$];
  exp_t          sb[$];
  logic [DW-1:0] mregs [16];
  logic [15:0]   mbusy;
  int            n_checks = 0;
  int            n_fail   = 0;

  function automatic vec_t mk(logic e0, logic [AW-1:0] a0, logic [DW-1:0] d0,
                              logic e1, logic [AW-1:0] a1, logic [DW-1:0] d1,
                              logic r, logic [AW-1:0] ra_, logic sp,
                              logic [AW-1:0] rd, logic [DW-1:0] ed, logic eb);
    vec_t v;
    v.we0 = e0; v.wa0 = a0; v.wd0 = d0;
    v.we1 = e1; v.wa1 = a1; v.wd1 = d1;
    v.rsv = r;  v.rsa = ra_;
    v.spread = sp; v.ra = rd; v.exp_d = ed; v.exp_b = eb;
    return v;
  endfunction

  function automatic vec_t idle(logic [AW-1:0] rd, logic [DW-1:0] ed, logic eb);
    return mk(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b0, rd, ed, eb);
  endfunction

  // Reference read: zero register, then forwarding (port 1 first), then stored state.
  function automatic exp_t model_read(logic [AW-1:0] a);
    exp_t e;
    if (a == 4'd0) begin
      e.d = 16'h0; e.b = 1'b0;
    end else if (we1 && wa1 == a) begin
      e.d = wd1; e.b = 1'b0;
    end else if (we0 && wa0 == a) begin
      e.d = wd0; e.b = 1'b0;
    end else begin
      e.d = mregs[a]; e.b = mbusy[a];
    end
    return e;
  endfunction

  task automatic model_edge();
    if (we0 && wa0 != 4'd0) begin mregs[wa0] = wd0; mbusy[wa0] = 1'b0; end
    if (we1 && wa1 != 4'd0) begin mregs[wa1] = wd1; mbusy[wa1] = 1'b0; end
    if (rsv && rsa != 4'd0) mbusy[rsa] = 1'b1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mregs[i] = 16'h0;
    mbusy = 16'h0;
  endtask

  task automatic cmp(string nm, int k, logic [DW-1:0] gd, logic gb,
                     logic [DW-1:0] ed, logic eb);
    n_checks++;
    if (gd !== ed || gb !== eb) begin
      n_fail++;
      $display("FAIL %s port %0d: got data=%h busy=%b, expected data=%h busy=%b",
               nm, k, gd, gb, ed, eb);
    end
  endtask

  // Set port addresses and queue the model's expectation for every port.
  task automatic set_reads(logic [AW-1:0] base, logic sp);
    for (int k = 0; k < NR; k++) begin
      logic [AW-1:0] a;
      a = sp ? base + AW'(k) : base;
      read_addr[k*AW +: AW] = a;
      sb.push_back(model_read(a));
    end
  endtask

  // Pop the queued expectations and compare them to all read ports.
  task automatic check_ports(string nm);
    for (int k = 0; k < NR; k++) begin
      exp_t e;
      if (sb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL %s port %0d: scoreboard empty", nm, k);
      end else begin
        e = sb.pop_front();
        cmp(nm, k, read_data[k*DW +: DW], read_busy[k], e.d, e.b);
      end
    end
  endtask

  task automatic drive_idle();
    we0 = 1'b0; wa0 = 4'd0; wd0 = 16'h0;
    we1 = 1'b0; wa1 = 4'd0; wd1 = 16'h0;
    rsv = 1'b0; rsa = 4'd0;
  endtask

  initial begin
    vec_t v;
    drive_idle();
    read_addr = '0;
    model_reset();

    // Table: zero register, sequential fill, collision, disabled sweep, scoreboard.
    tbl.push_back(mk(1'b1, 4'd0, 16'hA5A5, 1'b1, 4'd0, 16'hA5A5, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0, 1'b0));
    tbl.push_back(idle(4'd0, 16'h0, 1'b0));
    for (int i = 1; i < 16; i++) begin
      tbl.push_back(mk(1'b1, 4'(i), 16'(i), 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 1'b0, 4'(i), 16'(i), 1'b0));
      tbl.push_back(idle(4'(i), 16'(i), 1'b0));
    end
    tbl.push_back(mk(1'b1, 4'd5, 16'h1111, 1'b1, 4'd5, 16'h2222, 1'b0, 4'd0, 1'b0, 4'd5, 16'h2222, 1'b0));
    tbl.push_back(idle(4'd5, 16'h2222, 1'b0));
    for (int i = 0; i < 16; i++) begin
      logic [DW-1:0] ex;
      ex = (i == 0) ? 16'h0 : (i == 5) ? 16'h2222 : 16'(i);
      tbl.push_back(mk(1'b0, 4'(i), 16'hA5A5, 1'b0, 4'(i), 16'hA5A5, 1'b0, 4'd0, 1'b1, 4'(i), ex, 1'b0));
    end
    tbl.push_back(mk(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd3, 1'b0, 4'd3, 16'h0003, 1'b0));
    tbl.push_back(idle(4'd3, 16'h0003, 1'b1));
    tbl.push_back(mk(1'b0, 4'd0, 16'h0, 1'b1, 4'd3, 16'h0333, 1'b0, 4'd0, 1'b0, 4'd3, 16'h0333, 1'b0));
    tbl.push_back(idle(4'd3, 16'h0333, 1'b0));
    tbl.push_back(mk(1'b1, 4'd7, 16'h0777, 1'b0, 4'd0, 16'h0, 1'b1, 4'd7, 1'b0, 4'd7, 16'h0777, 1'b0));
    tbl.push_back(idle(4'd7, 16'h0777, 1'b1));
    tbl.push_back(mk(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd0, 1'b0, 4'd0, 16'h0, 1'b0));
    tbl.push_back(idle(4'd0, 16'h0, 1'b0));
    tbl.push_back(mk(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd7, 1'b1, 4'd7, 16'h0777, 1'b1));
    tbl.push_back(idle(4'd7, 16'h0777, 1'b1));

    // Reset held for two cycles; everything reads zero.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    set_reads(4'd1, 1'b1);
    #2;
    check_ports("reset_hold");
    for (int k = 0; k < NR; k++) cmp("reset_const", k, read_data[k*DW +: DW], read_busy[k], 16'h0, 1'b0);
    rst_n = 1'b1;

    // Apply table: drive at negedge, compare before the next rising edge.
    for (int n = 0; n < tbl.size(); n++) begin
      v = tbl[n];
      @(negedge clk);
      we0 = v.we0; wa0 = v.wa0; wd0 = v.wd0;
      we1 = v.we1; wa1 = v.wa1; wd1 = v.wd1;
      rsv = v.rsv; rsa = v.rsa;
      set_reads(v.ra, v.spread);
      #2;
      check_ports($sformatf("vec%0d", n));
      cmp($sformatf("vec%0d_const", n), 0, read_data[DW-1:0], read_busy[0], v.exp_d, v.exp_b);
      model_edge();
    end

    // Asynchronous reset asserted mid-cycle, away from any clock edge.
    @(posedge clk);
    #1;
    drive_idle();
    read_addr = {4'd15, 4'd5, 4'd1, 4'd3, 4'd7};
    for (int k = 0; k < NR; k++) sb.push_back(model_read(read_addr[k*AW +: AW]));
    #1;
    check_ports("pre_async");
    cmp("pre_async_busy7", 0, read_data[DW-1:0], read_busy[0], 16'h0777, 1'b1);
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < NR; k++) sb.push_back(model_read(read_addr[k*AW +: AW]));
    check_ports("async_reset");
    for (int k = 0; k < NR; k++) cmp("async_const", k, read_data[k*DW +: DW], read_busy[k], 16'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_reads(4'd1, 1'b1);
    #2;
    check_ports("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Parametrised multi-port register file: next generation of the MERC-16 register file.
- Adds configurable width, depth and read-port count, a second write port with defined priority, optional write-to-read bypass, and a per-register busy scoreboard for hazard detection.
- Sits in the decode stage. Feeds operand muxes and hazard logic; written back from the ALU and load/store writeback paths.

Parameters:
- DATA_WIDTH, 16, bits per register.
- ADDR_WIDTH, 4, register address bits; depth = 2**ADDR_WIDTH.
- NUM_READ, 5, number of independent read ports (>=1).
- ZERO_REG, 1, when 1, register 0 reads as 0 and ignores writes and reserves.
- BYPASS, 1, when 1, same-cycle write data is forwarded to matching read ports.

Ports:
- Clock  in  1  system clock, rising edge.
- ResetN  in  1  asynchronous active-low reset.
- ReadAddr  in  NUM_READ*ADDR_WIDTH  packed read addresses; port k = bits [k*ADDR_WIDTH +: ADDR_WIDTH]. Narrow (short) addresses are zero-extended by the caller.
- ReadData  out  NUM_READ*DATA_WIDTH  packed read data; port k = bits [k*DATA_WIDTH +: DATA_WIDTH].
- ReadBusy  out  NUM_READ  scoreboard busy flag for each read port's address.
- WriteEnable0  in  1  write port 0 enable.
- WriteAddr0  in  ADDR_WIDTH  write port 0 address.
- WriteData0  in  DATA_WIDTH  write port 0 data.
- WriteEnable1  in  1  write port 1 enable (higher priority).
- WriteAddr1  in  ADDR_WIDTH  write port 1 address.
- WriteData1  in  DATA_WIDTH  write port 1 data.
- ReserveEnable  in  1  mark a destination register busy.
- ReserveAddr  in  ADDR_WIDTH  register to mark busy.

Behaviour:
- Clock is a single domain. ResetN is asynchronous active-low: assertion immediately clears all registers to 0 and all busy bits to 0. Deassertion is synchronised externally.
- Reads are combinational (0-cycle latency). ReadData[k] = reg[ReadAddr[k]], subject to the bypass and zero-register rules below.
- Writes commit on the rising edge of Clock when the port's enable is 1.
- Both write ports targeting the same address in one cycle: WriteData1 is stored; port 0 is dropped.
- ZERO_REG=1:
  - Writes and reserves to address 0 are ignored.
  - Reads of address 0 return 0.
  - ReadBusy for address 0 is 0.
  - Bypass never applies to address 0.
- BYPASS=1: if a read address matches an enabled write address in the same cycle, ReadData returns that write's data (port 1 over port 0), and ReadBusy for that port is 0.
- BYPASS=0: read data reflects stored state only. New data is visible the cycle after the edge.
- Scoreboard: one busy bit per register.
  - Set on the edge when ReserveEnable=1 for ReserveAddr.
  - Cleared on the edge when either write port writes that address.
  - Reserve and write to the same address in the same cycle: busy ends set (reserve wins; the write is the older producer). The data write still commits.
  - Reserve is not bypassed: ReadBusy reflects the new reservation from the next cycle.
- Reserve to an already-busy register leaves it busy. This is not an error.
- ResetN asserted mid-operation: all state clears in the same instant. Writes in flight are lost.
- Without ZERO_REG, address 0 behaves as an ordinary register.
- All addresses are in range by construction; there is no wrap-around handling.

Test Plan:
- Reset then zero register: ResetN=0 for 2 cycles; all ReadData=0 and ReadBusy=0. Write 16'hA5A5 to address 0 on both ports -> reads of address 0 stay 0x0000.
- Sequential fill: for i=1..15 write i on port 0 -> the next cycle every read port addressed to i returns i. With BYPASS=1 the value is already visible in the write cycle; with BYPASS=0 it is not.
- Dual-write collision: WriteAddr0=WriteAddr1=5, WriteData0=16'h1111, WriteData1=16'h2222 -> address 5 reads 0x2222. Same-cycle bypass also shows 0x2222.
- Write disabled: both enables 0, data 16'hA5A5, sweep all addresses -> register contents unchanged (register i still reads i).
- Scoreboard:
  - Reserve address 3 -> ReadBusy=1 on ports addressing 3 the next cycle.
  - Port 1 writes 3 -> busy shows 0 immediately (BYPASS=1) and stays 0 after the edge.
  - Reserve and write address 7 in the same cycle -> 7 reads the new data and busy=1.
- Async reset mid-run: after the fill, pulse ResetN low mid-cycle (not aligned to a clock edge) -> all ReadData and ReadBusy go to 0 before the next edge.
